sfp_rx_capture_writer: RTL

// Captures one 32-bit Avalon-ST receive packet from the SFP datapath into the 1024x32 on-chip capture RAM.

---
 rtl/sfp_rx_capture_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sfp_rx_capture_writer.sv
// ---------------------------------------------------------------------------
// sfp_rx_capture_writer
//
// Captures one Avalon-ST receive packet from the SFP datapath into the
// on-chip capture RAM. Each accepted stream word is written through the
// RAM's s1 port, one word per clock. Software arms the block with start and
// capture_len, then reads the status outputs. The RAM contents are read back
// later over the system bus.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start, abort      1-cycle control pulses (abort has priority)
//   capture_len       maximum words to capture (0 or >DEPTH means DEPTH)
//   in_*              Avalon-ST sink (valid/ready/data/sop/eop/empty)
//   mem_*             registered RAM s1 write port
//   busy, done        FSM status (busy in ARMED/CAPTURE, done in DONE)
//   words_captured    words written in the current or last capture
//   truncated         sticky: length limit reached before eop
//   framing_err       sticky: sop seen while already capturing
// ---------------------------------------------------------------------------
module sfp_rx_capture_writer #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W:0]     capture_len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_sop,
   input  logic                in_eop,
   input  logic [1:0]          in_empty,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_clken,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W:0]     words_captured,
   output logic                truncated,
   output logic                framing_err
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                trunc_q, trunc_d;
   logic                ferr_q, ferr_d;
   logic                ready_q;
   logic                clken_q;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [BE_W-1:0]     be_q, be_d;

   logic                accept;
   logic                armReq;
   logic [ADDR_W:0]     lenClamped;
   logic [ADDR_W:0]     wordsInc;
   logic [BE_W-1:0]     beWord;

   // The RAM never back-pressures, so ready is simply "out of reset".
   assign accept     = in_valid & ready_q;
   // Abort suppresses a simultaneous start.
   assign armReq     = start & ~abort;
   assign lenClamped = ((capture_len == '0) || (capture_len > DEPTH_C)) ? DEPTH_C : capture_len;
   assign wordsInc   = words_q + ONE_C;
   // On the eop word, empty lanes are dropped from the low end (bits [7:0] are the last byte).
   assign beWord     = in_eop ? ({BE_W{1'b1}} << in_empty) : {BE_W{1'b1}};

   // Next-state logic: FSM transitions plus the write request and status
   // updates that go with each accepted word. Everything defaults to hold.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      words_d = words_q;
      trunc_d = trunc_q;
      ferr_d  = ferr_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;

      case (state_q)
         IDLE, DONE: begin
            if (armReq) begin
               state_d = ARMED;
               len_d   = lenClamped;
               words_d = '0;
               trunc_d = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         ARMED: begin
            // Only a sop word opens the capture; anything before it is dropped.
            if (accept && in_sop) begin
               wr_d    = 1'b1;
               addr_d  = '0;
               data_d  = in_data;
               be_d    = beWord;
               words_d = ONE_C;
               if (in_eop) begin
                  state_d = DONE;
               end else if (len_q == ONE_C) begin
                  state_d = DONE;
                  trunc_d = 1'b1;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            // words_q < len_q <= DEPTH here, so the low bits are a valid address.
            if (accept) begin
               wr_d    = 1'b1;
               addr_d  = words_q[ADDR_W-1:0];
               data_d  = in_data;
               be_d    = beWord;
               words_d = wordsInc;
               if (in_sop) begin
                  ferr_d = 1'b1;
               end
               if (in_eop) begin
                  state_d = DONE;
               end else if (wordsInc == len_q) begin
                  state_d = DONE;
                  trunc_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort only redirects the FSM; a word accepted this cycle is still written.
      if (abort) begin
         state_d = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and status registers; the RAM port is fully registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q   <= '0;
         words_q <= '0;
         trunc_q <= 1'b0;
         ferr_q  <= 1'b0;
         ready_q <= 1'b0;
         clken_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
      end else begin
         len_q   <= len_d;
         words_q <= words_d;
         trunc_q <= trunc_d;
         ferr_q  <= ferr_d;
         ready_q <= 1'b1;
         clken_q <= 1'b1;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
      end
   end

   assign in_ready       = ready_q;
   assign mem_clken      = clken_q;
   assign mem_chipselect = wr_q;
   assign mem_write      = wr_q;
   assign mem_address    = addr_q;
   assign mem_writedata  = data_q;
   assign mem_byteenable = be_q;
   assign busy           = (state_q == ARMED) || (state_q == CAPTURE);
   assign done           = (state_q == DONE);
   assign words_captured = words_q;
   assign truncated      = trunc_q;
   assign framing_err    = ferr_q;

endmodule
